// File: rtl/matrix_uop_retire_merge_pkg.sv
// Shared encodings, enums and helpers for the matrix micro-op retire merger.
package matrix_uop_retire_merge_pkg;

    // Matrix instruction ids; MSTORE and MADD share a code since both pass straight through.
    localparam logic [1:0] NON_MATRIX_ID = 2'd0;
    localparam logic [1:0] MLOAD_ID      = 2'd1;
    localparam logic [1:0] MMUL_ID       = 2'd2;
    localparam logic [1:0] MSTORE_ID     = 2'd3;
    localparam logic [1:0] MADD_ID       = 2'd3;

    // Matrix operand types
    localparam logic [1:0] MATRIX_A = 2'd0;
    localparam logic [1:0] MATRIX_B = 2'd1;
    localparam logic [1:0] MATRIX_C = 2'd2;

    typedef enum logic {
        UOP_SINGLE = 1'b0,
        UOP_MULTI  = 1'b1
    } uop_class_t;

    typedef enum logic {
        MERGE_IDLE  = 1'b0,
        MERGE_ACCUM = 1'b1
    } merge_state_t;

    // Index of the final micro-op of an expanded macro: MLOAD spans row_size beats, MMUL row_size+1.
    function automatic int unsigned last_index(input logic [1:0] instr_id, input int unsigned row_size);
        return (instr_id == MLOAD_ID) ? row_size - 1 : row_size;
    endfunction

endpackage

// File: rtl/matrix_uop_merge_slot.sv
// Per-warp accumulation slot: merge state, beat counter and captured macro fields.
module matrix_uop_merge_slot
    import matrix_uop_retire_merge_pkg::*;
#(
    parameter int unsigned NUM_THREADS = 4,
    parameter int unsigned UUID_W      = 44,
    parameter int unsigned NR_BITS     = 6,
    parameter int unsigned MCNT_W      = 4
)(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_start,
    input  logic                   i_accum,
    input  logic                   i_clear,
    input  logic [UUID_W-1:0]      i_uuid,
    input  logic [NUM_THREADS-1:0] i_tmask,
    input  logic [NR_BITS-1:0]     i_rd,
    input  logic                   i_wb,
    output merge_state_t           o_state,
    output logic [MCNT_W-1:0]      o_cnt,
    output logic [UUID_W-1:0]      o_uuid,
    output logic [NUM_THREADS-1:0] o_tmask,
    output logic [NR_BITS-1:0]     o_rd,
    output logic                   o_wb
);

    // Start (or restart) capture, fold in a middle beat, or drop back to idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            o_state <= MERGE_IDLE;
            o_cnt   <= '0;
            o_uuid  <= '0;
            o_tmask <= '0;
            o_rd    <= '0;
            o_wb    <= 1'b0;
        end else if (i_start) begin
            o_state <= MERGE_ACCUM;
            o_cnt   <= MCNT_W'(1);
            o_uuid  <= i_uuid;
            o_tmask <= i_tmask;
            o_rd    <= i_rd;
            o_wb    <= i_wb;
        end else if (i_accum) begin
            o_cnt   <= o_cnt + MCNT_W'(1);
            o_tmask <= o_tmask | i_tmask;
            o_wb    <= o_wb | i_wb;
        end else if (i_clear) begin
            o_state <= MERGE_IDLE;
            o_cnt   <= '0;
        end
    end

endmodule

// File: rtl/matrix_uop_retire_merge.sv
// Rebuilds one retire event per matrix macro-instruction from the per-micro-op commit stream.
module matrix_uop_retire_merge
    import matrix_uop_retire_merge_pkg::*;
#(
    parameter int unsigned NUM_WARPS   = 4,
    parameter int unsigned NUM_THREADS = 4,
    parameter int unsigned UUID_W      = 44,
    parameter int unsigned NR_BITS     = 6,
    parameter int unsigned MCNT_W      = 4,
    localparam int unsigned WID_W      = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
)(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WID_W-1:0]       in_wid,
    input  logic [UUID_W-1:0]      in_uuid,
    input  logic [NUM_THREADS-1:0] in_tmask,
    input  logic [NR_BITS-1:0]     in_rd,
    input  logic                   in_wb,
    input  logic [1:0]             in_m_instr_id,
    input  logic [1:0]             in_m_type,
    input  logic [MCNT_W-1:0]      in_m_row_size,
    input  logic [MCNT_W-1:0]      in_m_count,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WID_W-1:0]       out_wid,
    output logic [UUID_W-1:0]      out_uuid,
    output logic [NUM_THREADS-1:0] out_tmask,
    output logic [NR_BITS-1:0]     out_rd_base,
    output logic                   out_wb,
    output logic [MCNT_W:0]        out_nuops,
    output logic                   err
);

    merge_state_t           w_state [NUM_WARPS];
    logic [MCNT_W-1:0]      w_cnt   [NUM_WARPS];
    logic [UUID_W-1:0]      w_uuid  [NUM_WARPS];
    logic [NUM_THREADS-1:0] w_tmask [NUM_WARPS];
    logic [NR_BITS-1:0]     w_rd    [NUM_WARPS];
    logic                   w_wb    [NUM_WARPS];

    logic                   r_out_valid;
    logic [WID_W-1:0]       r_out_wid;
    logic [UUID_W-1:0]      r_out_uuid;
    logic [NUM_THREADS-1:0] r_out_tmask;
    logic [NR_BITS-1:0]     r_out_rd_base;
    logic                   r_out_wb;
    logic [MCNT_W:0]        r_out_nuops;
    logic                   r_err;

    logic                   w_accept;
    logic                   w_is_mload_ab;
    logic                   w_bad_row;
    uop_class_t             w_class;
    logic [MCNT_W-1:0]      w_last;
    logic                   w_in_seq;
    logic                   w_emit;
    logic                   w_merged;
    logic                   w_err_set;
    logic                   w_start;
    logic                   w_accum;
    logic                   w_clear;

    assign in_ready = !r_out_valid || out_ready;
    assign w_accept = in_valid && in_ready;

    assign w_is_mload_ab = (in_m_instr_id == MLOAD_ID) &&
                           ((in_m_type == MATRIX_A) || (in_m_type == MATRIX_B));
    assign w_bad_row     = w_is_mload_ab && (in_m_row_size == '0);
    assign w_class       = ((w_is_mload_ab && !w_bad_row) || (in_m_instr_id == MMUL_ID))
                           ? UOP_MULTI : UOP_SINGLE;
    assign w_last        = MCNT_W'(last_index(in_m_instr_id, 32'(in_m_row_size)));
    assign w_in_seq      = (in_m_count == w_cnt[in_wid]) && (in_uuid == w_uuid[in_wid]);

    // One slot per warp; only the slot addressed by in_wid sees control strobes.
    for (genvar g = 0; g < NUM_WARPS; g++) begin : g_slot
        matrix_uop_merge_slot #(
            .NUM_THREADS (NUM_THREADS),
            .UUID_W      (UUID_W),
            .NR_BITS     (NR_BITS),
            .MCNT_W      (MCNT_W)
        ) u_slot (
            .clk     (clk),
            .reset   (reset),
            .i_start (w_start && (in_wid == WID_W'(g))),
            .i_accum (w_accum && (in_wid == WID_W'(g))),
            .i_clear (w_clear && (in_wid == WID_W'(g))),
            .i_uuid  (in_uuid),
            .i_tmask (in_tmask),
            .i_rd    (in_rd),
            .i_wb    (in_wb),
            .o_state (w_state[g]),
            .o_cnt   (w_cnt[g]),
            .o_uuid  (w_uuid[g]),
            .o_tmask (w_tmask[g]),
            .o_rd    (w_rd[g]),
            .o_wb    (w_wb[g])
        );
    end

    // Decide what an accepted beat does to its warp slot, the output entry and the error flag.
    always_comb begin
        w_emit    = 1'b0;
        w_merged  = 1'b0;
        w_err_set = 1'b0;
        w_start   = 1'b0;
        w_accum   = 1'b0;
        w_clear   = 1'b0;
        if (w_accept) begin
            if (w_bad_row) begin
                w_err_set = 1'b1;
            end
            if (w_class == UOP_SINGLE) begin
                w_emit = 1'b1;
                if (w_state[in_wid] == MERGE_ACCUM) begin
                    w_err_set = 1'b1;
                end
            end else if (w_state[in_wid] == MERGE_IDLE) begin
                if (in_m_count != '0) begin
                    w_err_set = 1'b1;
                end else if (w_last == '0) begin
                    w_emit = 1'b1;
                end else begin
                    w_start = 1'b1;
                end
            end else if (w_in_seq) begin
                if (in_m_count == w_last) begin
                    w_emit   = 1'b1;
                    w_merged = 1'b1;
                    w_clear  = 1'b1;
                end else begin
                    w_accum = 1'b1;
                end
            end else begin
                // Broken sequence: drop the partial macro, restart only from a count-0 beat.
                w_err_set = 1'b1;
                w_clear   = 1'b1;
                if (in_m_count == '0) begin
                    if (w_last == '0) begin
                        w_emit = 1'b1;
                    end else begin
                        w_start = 1'b1;
                    end
                end
            end
        end
    end

    // One-entry output holding register plus sticky error flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_out_valid   <= 1'b0;
            r_out_wid     <= '0;
            r_out_uuid    <= '0;
            r_out_tmask   <= '0;
            r_out_rd_base <= '0;
            r_out_wb      <= 1'b0;
            r_out_nuops   <= '0;
            r_err         <= 1'b0;
        end else begin
            if (w_emit) begin
                r_out_valid   <= 1'b1;
                r_out_wid     <= in_wid;
                r_out_uuid    <= in_uuid;
                r_out_tmask   <= w_merged ? (w_tmask[in_wid] | in_tmask) : in_tmask;
                r_out_rd_base <= w_merged ? w_rd[in_wid] : in_rd;
                r_out_wb      <= w_merged ? (w_wb[in_wid] | in_wb) : in_wb;
                r_out_nuops   <= w_merged ? ((MCNT_W+1)'(w_cnt[in_wid]) + (MCNT_W+1)'(1))
                                          : (MCNT_W+1)'(1);
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (w_err_set) begin
                r_err <= 1'b1;
            end
        end
    end

    assign out_valid   = r_out_valid;
    assign out_wid     = r_out_wid;
    assign out_uuid    = r_out_uuid;
    assign out_tmask   = r_out_tmask;
    assign out_rd_base = r_out_rd_base;
    assign out_wb      = r_out_wb;
    assign out_nuops   = r_out_nuops;
    assign err         = r_err;

endmodule

// File: doc/matrix_uop_retire_merge.md
Name: matrix_uop_retire_merge

Overview:
- Commit-side counterpart of the matrix micro-op expander in the ibuffer.
- Consumes the per-micro-op commit stream and rebuilds one retire event per matrix macro-instruction (MLOAD A/B, MMUL).
- Non-expanded instructions pass straight through: non-matrix, MLOAD C, MSTORE and MADD.
- Sits between the commit arbiter and the warp scoreboard/retire counters.

Parameters:
- NUM_WARPS, 4, warps tracked; WID_W = max(1, clog2(NUM_WARPS)).
- NUM_THREADS, 4, thread-mask width.
- UUID_W, 44, instruction UUID width.
- NR_BITS, 6, register index width.
- MCNT_W, 4, width of m_instr_count and m_row_size.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  micro-op commit valid.
- in_ready  out  1  micro-op commit accepted.
- in_wid  in  WID_W  warp id.
- in_uuid  in  UUID_W  macro UUID; shared by all micro-ops of one macro.
- in_tmask  in  NUM_THREADS  thread mask.
- in_rd  in  NR_BITS  micro-op destination register.
- in_wb  in  1  micro-op writes back.
- in_m_instr_id  in  2  matrix instruction id; 0 = not matrix.
- in_m_type  in  2  matrix A/B/C.
- in_m_row_size  in  MCNT_W  macro row size.
- in_m_count  in  MCNT_W  micro-op index within the macro.
- out_valid  out  1  merged retire valid.
- out_ready  in  1  downstream accepts.
- out_wid  out  WID_W  warp id.
- out_uuid  out  UUID_W  macro UUID.
- out_tmask  out  NUM_THREADS  OR of all micro-op tmasks.
- out_rd_base  out  NR_BITS  rd of micro-op 0.
- out_wb  out  1  OR of all micro-op wb bits.
- out_nuops  out  MCNT_W+1  number of micro-ops merged.
- err  out  1  sticky protocol error.

Behaviour:
- Reset (reset low, asynchronous):
  - All warp states IDLE; counters 0.
  - out_valid=0, err=0, and all out_* data = 0.
- Classification of each micro-op:
  - MULTI: m_instr_id==MLOAD with m_type A/B, or m_instr_id==MMUL.
  - SINGLE: everything else.
- Last index of a macro: MLOAD A/B = row_size-1; MMUL = row_size.
- A row_size of 0 on an MLOAD A/B is an error; the micro-op is treated as SINGLE.
- Output holding register: one entry.
  - in_ready = !out_valid || out_ready. in_ready does not depend on in_valid.
  - A beat is accepted when in_valid && in_ready.
- SINGLE beat:
  - Output loads on the next edge with nuops=1 and rd_base=in_rd.
  - Latency is one cycle.
- MULTI beat, per-warp FSM for in_wid:
  - IDLE, m_count==0, not last: go to ACCUM. Capture uuid, tmask, rd, wb; cnt=1. Nothing is output.
  - IDLE, m_count!=0: set err. The beat is dropped and the state stays IDLE.
  - ACCUM, m_count==cnt and uuid matches, not last: OR tmask and wb; cnt++.
  - ACCUM, m_count==cnt and uuid matches, last: output the merged entry on the next edge with nuops=cnt+1. Warp returns to IDLE.
  - ACCUM with a count or uuid mismatch: set err. Discard the accumulation; warp returns to IDLE. If the beat has m_count==0, restart the accumulation from that beat.
- Single-beat macro (last==0, e.g. MMUL with row_size 0, or IDLE with m_count==0 that is also last): behaves like SINGLE with nuops=1.
- Interleaving:
  - Micro-ops of different warps may interleave freely.
  - Within one warp they arrive in order.
  - A SINGLE beat for a warp that is in ACCUM sets err. The SINGLE beat is still emitted and the accumulation is kept.
- Output stability: out_* data is stable while out_valid && !out_ready. Back-to-back completions sustain 1 per cycle when out_ready=1.
- Accumulation while stalled: absorbed beats need no output slot, but in_ready still follows the rule above. The design is simple, with no bypass.
- err clears only on reset.

Decomposition:
- Shared package: MLOAD_ID/MMUL_ID/MSTORE_ID/MADD_ID and MATRIX_A/B/C encodings, the uop_class_t enum (SINGLE/MULTI), the merge_state_t enum (IDLE/ACCUM), and the function that computes the last index.
- Sub-module: matrix_uop_merge_slot, one per warp. It holds the state, counter and captured fields, and is instantiated NUM_WARPS times.
- The top level contains the classification logic, the output register and the error flag.

Test Plan:
1. SINGLE pass-through: non-matrix beat on wid 2, uuid 7, tmask 4'b1011 -> one cycle later out_valid with nuops=1, tmask 4'b1011, rd_base = in_rd.
2. MLOAD A, row_size 4, wid 1, counts 0..3, rd 8..11, tmasks 0001/0010/0100/1000 -> exactly one output, one cycle after count 3: nuops=4, rd_base=8, tmask=1111.
3. MMUL, row_size 2, wid 0, counts 0,1,2 -> one output with nuops=3. Then MLOAD C -> a separate output with nuops=1.
4. Interleaving: MLOAD B on warp 0 (row_size 2) and warp 3 (row_size 3), beats alternating, with out_ready low for 3 cycles mid-stream -> two outputs in completion order with correct nuops 2/3. No beat is lost; out_* holds stable while stalled.
5. Errors: warp 1 gets count 0 then count 2 (skipping 1) -> err=1 and warp back to IDLE. Then warp 1 gets count 1 from IDLE -> dropped, err stays 1.
6. Reset mid-accumulation: after 2 of 4 beats, pulse reset low asynchronously -> out_valid=0 and err=0 immediately. A fresh 4-beat MLOAD then completes normally with nuops=4.
